// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op codes, FSM state codes and the latched op decode bundle.
package mul_div_unit_pkg;

    localparam int OP_W        = 3;
    localparam int MD_OP_BUS_W = OP_W;

    typedef enum logic [OP_W-1:0] {
        MDU_OP_MULL  = 3'd0,
        MDU_OP_MULH  = 3'd1,
        MDU_OP_MULHU = 3'd2,
        MDU_OP_DIVS  = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_REMS  = 3'd5,
        MDU_OP_REMU  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_FIX  = 2'd2,
        MDU_ST_DONE = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic is_div;
        logic is_rem;
        logic is_hi;
        logic is_sgn;
    } mdu_dec_t;

    // Unknown codes fall back to MULL.
    function automatic mdu_dec_t mdu_decode(input logic [OP_W-1:0] op);
        mdu_dec_t d;
        d = '0;
        case (op)
            MDU_OP_MULH:  begin d.is_hi = 1'b1; d.is_sgn = 1'b1; end
            MDU_OP_MULHU: begin d.is_hi = 1'b1; end
            MDU_OP_DIVS:  begin d.is_div = 1'b1; d.is_sgn = 1'b1; end
            MDU_OP_DIVU:  begin d.is_div = 1'b1; end
            MDU_OP_REMS:  begin
                d.is_div = 1'b1;
                d.is_rem = 1'b1;
                d.is_sgn = 1'b1;
            end
            MDU_OP_REMU:  begin d.is_div = 1'b1; d.is_rem = 1'b1; end
            default:      begin d.is_sgn = 1'b1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result handshake bundle between the EX stage (master)
// and the multiply/divide unit (slave).
//   in_valid/in_ready/op/in_0/in_1 : operand channel
//   out_valid/out_ready/out/of/dz  : result channel
interface mul_div_unit_if import mul_div_unit_pkg::*; #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in_0;
    logic [DATA_W-1:0] in_1;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              of;
    logic              dz;

    modport master (
        output in_valid, op, in_0, in_1, out_ready,
        input  in_ready, out_valid, out, of, dz
    );

    modport slave (
        input  in_valid, op, in_0, in_1, out_ready,
        output in_ready, out_valid, out, of, dz
    );
endinterface

// File: rtl/mul_div_unit_div_core.sv
// Restoring divider: one quotient bit per i_step, unsigned magnitudes.
// Ports: i_clk, i_reset (sync, active-low), i_load, i_step,
//   i_dividend, i_divisor -> o_quo, o_rem. Built only with MDU_DIV_EN.
`ifdef MDU_DIV_EN
module mdu_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem
);
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_diff;

    // Partial remainder shifted left with the next dividend bit.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_ge    = w_shift >= {1'b0, i_divisor};
    // Only taken when w_ge, so the result always fits DATA_W bits.
    assign w_diff  = w_shift[DATA_W-1:0] - i_divisor;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_quo <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_quo <= i_dividend;
            r_rem <= '0;
        end else if (i_step) begin
            if (w_ge) begin
                r_rem <= w_diff;
                r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign o_quo = r_quo;
    assign o_rem = r_rem;
endmodule
`endif

// File: rtl/mul_div_unit.sv
// Iterative MUL/MULH/MULHU/DIV/REM unit, one op in flight, 1 bit/cycle.
// Ports: i_clk, i_reset (sync, active-low), i_flush, bus (slave side
// of mul_div_unit_if). Macro MDU_DIV_EN enables the divider datapath;
// without it DIV*/REM* return out=0, of=0, dz=1 on the fast path.
module mul_div_unit import mul_div_unit_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e          r_state;
    mdu_state_e          w_next;
    mdu_dec_t            w_dec;
    mdu_dec_t            r_dec;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_accept;
    logic                w_fast;
    logic                w_load;
    logic                w_step;
    logic                w_fix;
    logic                w_last;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_prod;

    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [DATA_W-1:0]   w_mul_res;
    logic                w_mul_of;
    logic [DATA_W-1:0]   w_res;
    logic                w_res_of;

    logic [DATA_W-1:0]   w_fast_out;
    logic                w_fast_of;
    logic                w_fast_dz;

    logic [DATA_W-1:0]   r_out;
    logic                r_of;
    logic                r_dz;

    // ---------------- operand conditioning ----------------
    assign w_dec    = mdu_decode(bus.op);
    assign w_a_neg  = w_dec.is_sgn & bus.in_0[DATA_W-1];
    assign w_b_neg  = w_dec.is_sgn & bus.in_1[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -bus.in_0 : bus.in_0;
    assign w_b_mag  = w_b_neg ? -bus.in_1 : bus.in_1;
    assign w_accept = bus.in_valid & w_in_ready & ~i_flush;
    assign w_last   = r_cnt == CNT_W'(DATA_W - 1);

    // ---------------- fast path and divider ----------------
`ifdef MDU_DIV_EN
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              w_dz;
    logic              w_ovf;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;
    logic [DATA_W-1:0] w_quo_s;
    logic [DATA_W-1:0] w_rem_s;

    assign w_dz   = w_dec.is_div & (bus.in_1 == '0);
    assign w_ovf  = w_dec.is_div & w_dec.is_sgn
                  & (bus.in_0 == MIN_NEG) & (bus.in_1 == '1);
    assign w_fast = w_dz | w_ovf;

    always_comb begin
        w_fast_out = '0;
        w_fast_of  = 1'b0;
        w_fast_dz  = 1'b0;
        if (w_dz) begin
            w_fast_out = w_dec.is_rem ? bus.in_0 : '1;
            w_fast_dz  = 1'b1;
        end else begin
            w_fast_out = w_dec.is_rem ? '0 : MIN_NEG;
            w_fast_of  = 1'b1;
        end
    end

    mdu_div_core #(
        .DATA_W     (DATA_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_step     (w_step & r_dec.is_div),
        .i_dividend (w_a_mag),
        .i_divisor  (r_b),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

    // Quotient sign = sign(a)^sign(b); remainder follows dividend.
    assign w_quo_s  = r_neg_q ? -w_quo : w_quo;
    assign w_rem_s  = r_neg_r ? -w_rem : w_rem;
    assign w_res    = !r_dec.is_div ? w_mul_res
                    : (r_dec.is_rem ? w_rem_s : w_quo_s);
    assign w_res_of = !r_dec.is_div & w_mul_of;
`else
    logic w_unused_div;

    assign w_fast     = w_dec.is_div;
    assign w_fast_out = '0;
    assign w_fast_of  = 1'b0;
    assign w_fast_dz  = 1'b1;
    assign w_res      = w_mul_res;
    assign w_res_of   = w_mul_of;
    assign w_unused_div = ^{r_dec.is_rem, r_dec.is_div, r_neg_r};
`endif

    // ---------------- multiplier ----------------
    // Shift-add: upper half accumulates, lower half shifts out the
    // multiplier LSB-first; w_sum keeps the carry for the shift.
    assign w_sum = {1'b0, r_prod[2*DATA_W-1:DATA_W]}
                 + (r_prod[0] ? {1'b0, r_a} : '0);

    assign w_prod_s  = r_neg_q ? -r_prod : r_prod;
    assign w_mul_res = r_dec.is_hi ? w_prod_s[2*DATA_W-1:DATA_W]
                                   : w_prod_s[DATA_W-1:0];
    // Signed product fits DATA_W bits iff its top DATA_W+1 bits agree.
    assign w_mul_of  = !r_dec.is_hi
                     & !((&w_prod_s[2*DATA_W-1:DATA_W-1])
                     | ~(|w_prod_s[2*DATA_W-1:DATA_W-1]));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= MDU_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = MDU_ST_IDLE;
        end else begin
            unique case (r_state)
                MDU_ST_IDLE: begin
                    if (w_accept) begin
                        w_next = w_fast ? MDU_ST_DONE : MDU_ST_CALC;
                    end
                end
                MDU_ST_CALC: begin
                    if (w_last) begin
                        w_next = MDU_ST_FIX;
                    end
                end
                MDU_ST_FIX:  w_next = MDU_ST_DONE;
                MDU_ST_DONE: begin
                    if (bus.out_ready) begin
                        w_next = MDU_ST_IDLE;
                    end
                end
                default:     w_next = MDU_ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        unique case (r_state)
            MDU_ST_IDLE: w_in_ready  = 1'b1;
            MDU_ST_CALC: w_step      = 1'b1;
            MDU_ST_FIX:  w_fix       = ~i_flush;
            MDU_ST_DONE: w_out_valid = 1'b1;
            default:     w_in_ready  = 1'b0;
        endcase
    end

    assign w_load = w_accept;

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_dec   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_out   <= '0;
            r_of    <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            if (w_load) begin
                r_dec   <= w_dec;
                r_a     <= w_a_mag;
                r_b     <= w_b_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_cnt   <= '0;
                r_prod  <= {{DATA_W{1'b0}}, w_b_mag};
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_dec.is_div) begin
                    r_prod <= {w_sum, r_prod[DATA_W-1:1]};
                end
            end
            if (w_accept && w_fast) begin
                r_out <= w_fast_out;
                r_of  <= w_fast_of;
                r_dz  <= w_fast_dz;
            end else if (w_fix) begin
                r_out <= w_res;
                r_of  <= w_res_of;
                r_dz  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out       = r_out;
    assign bus.of        = r_of;
    assign bus.dz        = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (DATA_W=32): directed cases,
// randomized ops against an arithmetic model, backpressure, flush, reset.
module tb_mul_div_unit;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   failures;

    mul_div_unit_if #(.DATA_W(32)) bus ();

    mul_div_unit #(
        .DATA_W  (32)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_flush (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Returns {of, dz, out} from the arithmetic definition of each op.
    function automatic logic [33:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        logic [31:0] o;
        logic        f;
        logic        z;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        o  = p[31:0];
        f  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        z  = 1'b0;
        case (op)
            3'd1: begin o = p[63:32]; f = 1'b0; end
            3'd2: begin o = up[63:32]; f = 1'b0; end
            3'd3, 3'd4, 3'd5, 3'd6: begin
                f = 1'b0;
                o = '0;
`ifdef MDU_DIV_EN
                if (b == 32'd0) begin
                    z = 1'b1;
                    o = (op == 3'd3 || op == 3'd4) ? 32'hFFFF_FFFF : a;
                end else if ((op == 3'd3 || op == 3'd5)
                             && a == 32'h8000_0000
                             && b == 32'hFFFF_FFFF) begin
                    f = 1'b1;
                    o = (op == 3'd3) ? 32'h8000_0000 : 32'd0;
                end else if (op == 3'd3) begin
                    o = 32'(sa / sb);
                end else if (op == 3'd5) begin
                    o = 32'(sa % sb);
                end else if (op == 3'd4) begin
                    o = a / b;
                end else begin
                    o = a % b;
                end
`else
                z = 1'b1;
`endif
            end
            default: ;
        endcase
        return {f, z, o};
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (op >= 3'd3 && op <= 3'd6) begin
`ifdef MDU_DIV_EN
            if (b == 32'd0) return 1;
            if ((op == 3'd3 || op == 3'd5) && a == 32'h8000_0000
                && b == 32'hFFFF_FFFF) return 1;
            return 34;
`else
            return 1;
`endif
        end
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present an op; returns at the negedge of cycle T+1.
    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.in_0     = a;
        bus.in_1     = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid (bounded), holds `hold` cycles, then hands over.
    task automatic collect(input int hold, output logic [31:0] o,
                           output logic f, output logic z,
                           output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        o = bus.out;
        f = bus.of;
        z = bus.dz;
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out, bus.of, bus.dz}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state rdy=%b vld=%b out=%h of=%b dz=%b",
                     bus.in_ready, bus.out_valid, bus.out, bus.of, bus.dz);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rdy=%b vld=%b need 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_mul_directed();
        logic [2:0]  top [6] = '{3'd0, 3'd2, 3'd0, 3'd1, 3'd1, 3'd7};
        logic [31:0] ta  [6] = '{32'd7, 32'hFFFF_FFFF, 32'h1_0000,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
        logic [31:0] tb  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1_0000,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        logic [31:0] te  [6] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'd0,
                                 32'd0, 32'h4000_0000, 32'd15};
        logic        tf  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] o;
        logic        f;
        logic        z;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            issue(top[i], ta[i], tb[i]);
            collect(0, o, f, z, lat);
            checks++;
            if ({o, f, z} !== {te[i], tf[i], 1'b0}) begin
                failures++;
                $display("FAIL mul_dir%0d got %h of=%b dz=%b need %h of=%b",
                         i, o, f, z, te[i], tf[i]);
            end
            checks++;
            if (lat != 34) begin
                failures++;
                $display("FAIL mul_lat%0d got %0d need 34", i, lat);
            end
        end
    endtask

    task automatic test_div_directed();
        logic [2:0]  top [10] = '{3'd3, 3'd5, 3'd4, 3'd6, 3'd4,
                                  3'd3, 3'd5, 3'd6, 3'd3, 3'd5};
        logic [31:0] ta  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100,
                                  32'd100, 32'd5, 32'h8000_0000,
                                  32'h8000_0000, 32'd5, 32'd7, 32'd7};
        logic [31:0] tb  [10] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                                  32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [33:0] e;
        logic [31:0] o;
        logic        f;
        logic        z;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            e = model(top[i], ta[i], tb[i]);
            issue(top[i], ta[i], tb[i]);
            collect(0, o, f, z, lat);
            checks++;
            if ({f, z, o} !== e) begin
                failures++;
                $display("FAIL div_dir%0d got of=%b dz=%b %h need %h",
                         i, f, z, o, e);
            end
            checks++;
            if (lat != model_lat(top[i], ta[i], tb[i])) begin
                failures++;
                $display("FAIL div_lat%0d got %0d need %0d", i, lat,
                         model_lat(top[i], ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [33:0] e;
        logic [31:0] o;
        logic        f;
        logic        z;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            e  = model(op, a, b);
            issue(op, a, b);
            collect($urandom_range(0, 3), o, f, z, lat);
            checks++;
            if ({f, z, o} !== e || lat != model_lat(op, a, b)) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got %h/%0d need %h/%0d",
                         i, op, a, b, {f, z, o}, lat, e,
                         model_lat(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] e;
        logic [31:0] o;
        logic        f;
        logic        z;
        int          lat;
        e = model(3'd4, 32'd100, 32'd7);
        issue(3'd4, 32'd100, 32'd7);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.in_0     = 32'd7;
        bus.in_1     = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.of, bus.dz, bus.out}
                !== {2'b10, e}) begin
                failures++;
                $display("FAIL bp_hold%0d vld=%b rdy=%b got %h need %h",
                         i, bus.out_valid, bus.in_ready,
                         {bus.of, bus.dz, bus.out}, e);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_after_hs rdy=%b vld=%b need 1/0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_reaccept rdy=%b need 0", bus.in_ready);
        end
        collect(0, o, f, z, lat);
        checks++;
        if ({o, f, z, lat} !== {32'hFFFF_FFEB, 1'b0, 1'b0, 34}) begin
            failures++;
            $display("FAIL bp_next got %h of=%b dz=%b lat=%0d need ffffffeb/34",
                     o, f, z, lat);
        end
    endtask

    task automatic test_flush();
        int seen;
        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.in_0     = 32'd2;
        bus.in_1     = 32'd3;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_calc rdy=%b vld=%b need 1/0",
                     bus.in_ready, bus.out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_lost out_valid cycles=%0d need 0", seen);
        end
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_accept rdy=%b need 1", bus.in_ready);
        end
        issue(3'd0, 32'd4, 32'd5);
        repeat (40) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done vld=%b rdy=%b need 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] o;
        logic        f;
        logic        z;
        int          lat;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        collect(0, o, f, z, lat);
        issue(3'd0, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out, bus.of, bus.dz}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid rdy=%b vld=%b out=%h of=%b dz=%b",
                     bus.in_ready, bus.out_valid, bus.out, bus.of, bus.dz);
        end
        issue(3'd2, 32'd3, 32'd4);
        collect(0, o, f, z, lat);
        checks++;
        if ({o, f, z, lat} !== {32'd0, 1'b0, 1'b0, 34}) begin
            failures++;
            $display("FAIL reset_recover got %h lat=%0d need 0/34", o, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.in_0      = '0;
        bus.in_1      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_mul_directed();
        test_div_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
